mul_fu_scheduler: RTL

- Issue and sequencing controller for the 32x32 Wallace-tree multiplier functional unit in the Tomasulo core.
- Arbitrates round-robin among the multiply reservation stations, captures the winner's operands and tag, and drives the combinational multiplier.
- Carries the product and tag through a bubble-collapsing valid pipeline, then competes for the common data bus (CDB) with a req/gnt handshake and backpressure.

---
 rtl/mul_fu_scheduler.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mul_fu_scheduler.sv
// -----------------------------------------------------------------------------
// mul_fu_scheduler
//
// Issue and sequencing controller for the 32x32 multiplier functional unit.
// A round-robin arbiter picks one multiply reservation station per cycle. The
// winner's operands and tag are captured into stage 1, which drives the
// external combinational multiplier. Stage 2 captures the product, and later
// stages copy it forward. The last stage requests the CDB with a req/gnt
// handshake. Valid bits collapse bubbles, so a stalled result at the tail
// still lets younger operations move up behind it.
//
// Parameters:
//   NUM_RS  number of reservation stations (2..8)
//   TAG_W   tag width broadcast on the CDB
//   LAT     stages from grant to CDB request (2..6); stage 1 holds operands,
//           stages 2..LAT hold the product
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   rs_req_i    per-station issue request
//   rs_tag_i    flattened station tags, station i at [i*TAG_W +: TAG_W]
//   rs_opa_i    flattened operand A, station i at [i*32 +: 32]
//   rs_opb_i    flattened operand B, station i at [i*32 +: 32]
//   rs_gnt_o    one-hot issue grant, combinational in the accept cycle
//   mul_a_o     multiplier operand A (stage-1 register)
//   mul_b_o     multiplier operand B (stage-1 register)
//   mul_p_i     64-bit product from the multiplier, taken unsigned as-is
//   cdb_req_o   result valid at the last stage
//   cdb_gnt_i   CDB grant
//   cdb_tag_o   tag of the result at the last stage
//   cdb_data_o  product at the last stage
//   busy_o      any stage valid
//   flush_i     pipeline kill
//
// Build option:
//   MUL_SCHED_FLUSH_EN  when defined, flush_i clears every stage valid bit and
//                       blocks issue in that cycle. When it is not defined,
//                       flush_i is ignored.
// -----------------------------------------------------------------------------
module mul_fu_scheduler #(
  parameter int NUM_RS = 3,
  parameter int TAG_W  = 4,
  parameter int LAT    = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_RS-1:0]       rs_req_i,
  input  logic [NUM_RS*TAG_W-1:0] rs_tag_i,
  input  logic [NUM_RS*32-1:0]    rs_opa_i,
  input  logic [NUM_RS*32-1:0]    rs_opb_i,
  output logic [NUM_RS-1:0]       rs_gnt_o,
  output logic [31:0]             mul_a_o,
  output logic [31:0]             mul_b_o,
  input  logic [63:0]             mul_p_i,
  output logic                    cdb_req_o,
  input  logic                    cdb_gnt_i,
  output logic [TAG_W-1:0]        cdb_tag_o,
  output logic [63:0]             cdb_data_o,
  output logic                    busy_o,
  input  logic                    flush_i
);

  localparam int PTR_W = $clog2(NUM_RS);

  // Pipeline state, stages numbered 1..LAT
  logic [LAT:1]       v_q, v_d;
  logic [TAG_W-1:0]   tag_q [1:LAT];
  logic [TAG_W-1:0]   tag_d [1:LAT];
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [63:0]        data_q [2:LAT];
  logic [63:0]        data_d [2:LAT];
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  // take[k]: stage k can be written this edge (empty, or its occupant leaves)
  logic [LAT:1]       take;

  logic [NUM_RS-1:0]  gnt_oh;
  logic               found;
  logic               accept;
  logic               flush_act;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [TAG_W-1:0]   sel_tag;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;

`ifdef MUL_SCHED_FLUSH_EN
  assign flush_act = flush_i;
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign flush_act    = 1'b0;
`endif

  // Back-propagated readiness. The tail frees on cdb_gnt. Each earlier stage
  // frees when it is empty or when the stage ahead of it can be written.
  always_comb begin
    logic nxt;
    nxt  = cdb_gnt_i;
    take = '0;
    for (int k = LAT; k >= 1; k--) begin
      take[k] = ~v_q[k] | nxt;
      nxt     = take[k];
    end
  end

  // Round-robin search: the first requester at or after ptr_q, with wrap.
  always_comb begin
    found   = 1'b0;
    gnt_oh  = '0;
    ptr_nxt = '0;
    for (int off = 0; off < NUM_RS; off++) begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (!found && rs_req_i[i] &&
            ((int'(ptr_q) + off == i) || (int'(ptr_q) + off == i + NUM_RS))) begin
          found     = 1'b1;
          gnt_oh[i] = 1'b1;
          ptr_nxt   = (i == NUM_RS - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  assign accept   = found & take[1] & ~flush_act;
  assign rs_gnt_o = accept ? gnt_oh : '0;

  // Winner's operands and tag, selected by the one-hot grant
  always_comb begin
    sel_tag = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (gnt_oh[i]) begin
        sel_tag = rs_tag_i[i*TAG_W +: TAG_W];
        sel_a   = rs_opa_i[i*32 +: 32];
        sel_b   = rs_opb_i[i*32 +: 32];
      end
    end
  end

  // Next state. Payload registers load only when valid contents arrive, so a
  // bubble moving through a stage leaves the old payload in place and the CDB
  // outputs do not toggle needlessly.
  always_comb begin
    v_d    = v_q;
    tag_d  = tag_q;
    data_d = data_q;
    a_d    = a_q;
    b_d    = b_q;
    ptr_d  = ptr_q;

    for (int k = 3; k <= LAT; k++) begin
      if (take[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          tag_d[k]  = tag_q[k-1];
          data_d[k] = data_q[k-1];
        end
      end
    end

    // Stage 2 samples the multiplier output driven by the stage-1 operands
    if (take[2]) begin
      v_d[2] = v_q[1];
      if (v_q[1]) begin
        tag_d[2]  = tag_q[1];
        data_d[2] = mul_p_i;
      end
    end

    if (take[1]) begin
      v_d[1] = accept;
      if (accept) begin
        tag_d[1] = sel_tag;
        a_d      = sel_a;
        b_d      = sel_b;
      end
    end

    if (accept) begin
      ptr_d = ptr_nxt;
    end

    // Flush kills every in-flight result but keeps payloads and the pointer
    if (flush_act) begin
      v_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      ptr_q <= '0;
      for (int k = 1; k <= LAT; k++) begin
        tag_q[k] <= '0;
      end
      for (int k = 2; k <= LAT; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      a_q   <= a_d;
      b_q   <= b_d;
      ptr_q <= ptr_d;
      for (int k = 1; k <= LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
      for (int k = 2; k <= LAT; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign mul_a_o    = a_q;
  assign mul_b_o    = b_q;
  assign cdb_req_o  = v_q[LAT];
  assign cdb_tag_o  = tag_q[LAT];
  assign cdb_data_o = data_q[LAT];
  assign busy_o     = |v_q;

endmodule
